// File: rtl/dcache_access_scheduler_pkg.sv
// Shared codes for the data cache access scheduler: cache command/status
// encodings, access-width codes, arbiter FSM states and requester ownership.
// Optional build macro used by this slice: DCACHE_SCHED_MASK_EN.
package dcache_access_scheduler_pkg;

  // Command driven towards the data cache
  localparam logic [1:0] D_CACHE_NOP   = 2'b00;
  localparam logic [1:0] D_CACHE_LOAD  = 2'b01;
  localparam logic [1:0] D_CACHE_STORE = 2'b10;

  // Status reported by the data cache
  localparam logic [1:0] D_CACHE_RESTING = 2'b00;
  localparam logic [1:0] L_S_FINISHED    = 2'b10;

  // Access width codes (scalar type / vector vsew)
  localparam logic [2:0] ONE_BYTE  = 3'd0;
  localparam logic [2:0] TWO_BYTE  = 3'd1;
  localparam logic [2:0] FOUR_BYTE = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    YIELD = 2'd3
  } sched_state_e;

  typedef enum logic {
    OWN_SCALAR = 1'b0,
    OWN_VECTOR = 1'b1
  } owner_e;

  // Cache command for a transaction of the given direction
  function automatic logic [1:0] op_code(input logic is_store);
    return is_store ? D_CACHE_STORE : D_CACHE_LOAD;
  endfunction

endpackage

// File: rtl/dcache_access_scheduler_vec_elem_sequencer.sv
// Vector element sequencer: element counter, stride address accumulator,
// store-element selection and (with DCACHE_SCHED_MASK_EN) element mask lookup.
// Purpose: hold one vector request and walk it element by element.
// Latency: operands visible the cycle after load; adv moves to the next element in one cycle.
// Backpressure: none internally; the arbiter decides when to load and advance.
module vec_elem_sequencer
  import dcache_access_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        adv,
  input  logic [ADDR_WIDTH-1:0]       base,
  input  logic [ADDR_WIDTH-1:0]       stride,
  input  logic [ENTRY_INDEX_SIZE:0]   len,
  input  logic [2:0]                  typ,
  input  logic                        is_store,
  input  logic [VECTOR_SIZE*LEN-1:0]  wdata,
`ifdef DCACHE_SCHED_MASK_EN
  input  logic [VECTOR_SIZE-1:0]      mask,
`endif
  output logic [ENTRY_INDEX_SIZE-1:0] elem,
  output logic [ADDR_WIDTH-1:0]       cur_addr,
  output logic [LEN-1:0]              cur_wdata,
  output logic                        elem_active,
  output logic                        is_last,
  output logic [2:0]                  typ_q,
  output logic                        is_store_q
);

  logic [ADDR_WIDTH-1:0]     stride_q;
  logic [ENTRY_INDEX_SIZE:0] len_q;
  logic [LEN-1:0]            wdata_q [VECTOR_SIZE];
  logic [ENTRY_INDEX_SIZE:0] elem_ext;

  // Latch the request on load, then step element index and address on adv
  always_ff @(posedge clk) begin
    if (rst) begin
      elem       <= '0;
      cur_addr   <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      typ_q      <= '0;
      is_store_q <= 1'b0;
      for (int i = 0; i < VECTOR_SIZE; i++) wdata_q[i] <= '0;
    end else if (load) begin
      elem       <= '0;
      cur_addr   <= base;
      stride_q   <= stride;
      len_q      <= len;
      typ_q      <= typ;
      is_store_q <= is_store;
      for (int i = 0; i < VECTOR_SIZE; i++) wdata_q[i] <= wdata[i*LEN +: LEN];
    end else if (adv) begin
      elem     <= elem + 1'b1;
      // Two's-complement stride; the sum wraps modulo 2^ADDR_WIDTH
      cur_addr <= cur_addr + stride_q;
    end
  end

`ifdef DCACHE_SCHED_MASK_EN
  logic [VECTOR_SIZE-1:0] mask_q;

  // Mask is captured together with the rest of the vector request
  always_ff @(posedge clk) begin
    if (rst)       mask_q <= '0;
    else if (load) mask_q <= mask;
  end

  assign elem_active = mask_q[elem];
`else
  assign elem_active = 1'b1;
`endif

  assign elem_ext  = {1'b0, elem};
  assign is_last   = ((elem_ext + {{ENTRY_INDEX_SIZE{1'b0}}, 1'b1}) == len_q);
  assign cur_wdata = wdata_q[elem];

endmodule

// File: rtl/dcache_access_scheduler.sv
// Data cache access scheduler: shares the single cache port between the scalar
// and vector load/store units, splitting vector requests into element accesses.
// Build option: DCACHE_SCHED_MASK_EN adds the v_mask element-mask input.
// Purpose: arbitrate scalar/vector requests onto one data cache transaction port.
// Latency: ack three cycles after acceptance on a resting cache that finishes in one cycle.
// Backpressure: requests wait in ISSUE until the cache rests; requesters hold req until ack/done.
module dcache_access_scheduler
  import dcache_access_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_req,
  input  logic                        s_is_store,
  input  logic [ADDR_WIDTH-1:0]       s_addr,
  input  logic [2:0]                  s_type,
  input  logic [LEN-1:0]              s_wdata,
  output logic                        s_ack,
  output logic [LEN-1:0]              s_rdata,
  input  logic                        v_req,
  input  logic                        v_is_store,
  input  logic [ADDR_WIDTH-1:0]       v_base,
  input  logic [ADDR_WIDTH-1:0]       v_stride,
  input  logic [ENTRY_INDEX_SIZE:0]   v_len,
  input  logic [2:0]                  v_type,
  input  logic [VECTOR_SIZE*LEN-1:0]  v_wdata,
`ifdef DCACHE_SCHED_MASK_EN
  input  logic [VECTOR_SIZE-1:0]      v_mask,
`endif
  output logic                        v_elem_valid,
  output logic [ENTRY_INDEX_SIZE-1:0] v_elem_idx,
  output logic [LEN-1:0]              v_elem_data,
  output logic                        v_done,
  output logic                        busy,
  output logic [1:0]                  cache_vis_signal,
  output logic [ADDR_WIDTH-1:0]       data_addr,
  output logic [2:0]                  data_type,
  output logic [LEN-1:0]              cache_written_data,
  output logic [ENTRY_INDEX_SIZE:0]   length,
  input  logic [LEN-1:0]              data,
  input  logic [1:0]                  d_cache_vis_status
);

  sched_state_e state, state_d;
  owner_e       owner, owner_d;
  logic         parked, parked_d;

  logic                  s_store_q;
  logic [ADDR_WIDTH-1:0] s_addr_q;
  logic [2:0]            s_type_q;
  logic [LEN-1:0]        s_wdata_q;

  logic                        s_latch, seq_load, seq_adv, issue;
  logic                        ack_d, ev_d, done_d;
  logic [LEN-1:0]              rdata_d, ed_d;
  logic [ENTRY_INDEX_SIZE-1:0] idx_d;

  logic [ENTRY_INDEX_SIZE-1:0] seq_elem;
  logic [ADDR_WIDTH-1:0]       seq_addr;
  logic [LEN-1:0]              seq_wdata;
  logic                        seq_active, seq_last, seq_store;
  logic [2:0]                  seq_type;

  vec_elem_sequencer #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .LEN              (LEN),
    .VECTOR_SIZE      (VECTOR_SIZE),
    .ENTRY_INDEX_SIZE (ENTRY_INDEX_SIZE)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .load        (seq_load),
    .adv         (seq_adv),
    .base        (v_base),
    .stride      (v_stride),
    .len         (v_len),
    .typ         (v_type),
    .is_store    (v_is_store),
    .wdata       (v_wdata),
`ifdef DCACHE_SCHED_MASK_EN
    .mask        (v_mask),
`endif
    .elem        (seq_elem),
    .cur_addr    (seq_addr),
    .cur_wdata   (seq_wdata),
    .elem_active (seq_active),
    .is_last     (seq_last),
    .typ_q       (seq_type),
    .is_store_q  (seq_store)
  );

  // Arbiter state, owner and parked-vector flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= OWN_SCALAR;
      parked <= 1'b0;
    end else begin
      state  <= state_d;
      owner  <= owner_d;
      parked <= parked_d;
    end
  end

  // Next state, operand capture strobes and completion values
  always_comb begin
    state_d  = state;
    owner_d  = owner;
    parked_d = parked;
    s_latch  = 1'b0;
    seq_load = 1'b0;
    seq_adv  = 1'b0;
    issue    = 1'b0;
    ack_d    = 1'b0;
    rdata_d  = '0;
    ev_d     = 1'b0;
    idx_d    = '0;
    ed_d     = '0;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        // Scalar has priority; a concurrent vector is taken on a later IDLE
        if (s_req) begin
          s_latch = 1'b1;
          owner_d = OWN_SCALAR;
          state_d = ISSUE;
        end else if (v_req) begin
          seq_load = 1'b1;
          if (v_len == '0) begin
            done_d = 1'b1;
          end else begin
            owner_d = OWN_VECTOR;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Masked-off elements only advance the address, one per cycle
        if (owner == OWN_VECTOR && !seq_active) begin
          seq_adv = 1'b1;
          if (seq_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (d_cache_vis_status == D_CACHE_RESTING) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (d_cache_vis_status == L_S_FINISHED) begin
          if (owner == OWN_SCALAR) begin
            ack_d   = 1'b1;
            rdata_d = s_store_q ? '0 : data;
            // A scalar served between elements hands the port straight back
            if (parked) begin
              owner_d  = OWN_VECTOR;
              parked_d = 1'b0;
              state_d  = ISSUE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            if (!seq_store) begin
              ev_d  = 1'b1;
              idx_d = seq_elem;
              ed_d  = data;
            end
            seq_adv = 1'b1;
            if (seq_last) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = YIELD;
            end
          end
        end
      end
      YIELD: begin
        // One-cycle window where a waiting scalar preempts the vector
        state_d = ISSUE;
        if (s_req) begin
          s_latch  = 1'b1;
          owner_d  = OWN_SCALAR;
          parked_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scalar operand capture and registered completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      s_store_q    <= 1'b0;
      s_addr_q     <= '0;
      s_type_q     <= '0;
      s_wdata_q    <= '0;
      s_ack        <= 1'b0;
      s_rdata      <= '0;
      v_elem_valid <= 1'b0;
      v_elem_idx   <= '0;
      v_elem_data  <= '0;
      v_done       <= 1'b0;
    end else begin
      if (s_latch) begin
        s_store_q <= s_is_store;
        s_addr_q  <= s_addr;
        s_type_q  <= s_type;
        s_wdata_q <= s_wdata;
      end
      s_ack        <= ack_d;
      s_rdata      <= rdata_d;
      v_elem_valid <= ev_d;
      v_elem_idx   <= idx_d;
      v_elem_data  <= ed_d;
      v_done       <= done_d;
    end
  end

  // Cache command is only non-NOP in the single issuing cycle
  always_comb begin
    cache_vis_signal   = D_CACHE_NOP;
    data_addr          = '0;
    data_type          = '0;
    cache_written_data = '0;
    if (issue) begin
      if (owner == OWN_VECTOR) begin
        cache_vis_signal   = op_code(seq_store);
        data_addr          = seq_addr;
        data_type          = seq_type;
        cache_written_data = seq_wdata;
      end else begin
        cache_vis_signal   = op_code(s_store_q);
        data_addr          = s_addr_q;
        data_type          = s_type_q;
        cache_written_data = s_wdata_q;
      end
    end
  end

  assign busy   = (state != IDLE);
  assign length = {{ENTRY_INDEX_SIZE{1'b0}}, 1'b1};

endmodule

// File: tb/tb_dcache_access_scheduler.sv
// Bench for dcache_access_scheduler: cycle-by-cycle vector table plus
// hand sequences for arbitration, reset abandonment and (optionally) masking.
module tb_dcache_access_scheduler;
  import dcache_access_scheduler_pkg::*;

  localparam logic [1:0] ST_BUSY = 2'b01;

  logic         clk;
  logic         rst;
  logic         s_req, s_is_store;
  logic [16:0]  s_addr;
  logic [2:0]   s_type;
  logic [31:0]  s_wdata;
  logic         s_ack;
  logic [31:0]  s_rdata;
  logic         v_req, v_is_store;
  logic [16:0]  v_base, v_stride;
  logic [3:0]   v_len;
  logic [2:0]   v_type;
  logic [255:0] v_wdata;
`ifdef DCACHE_SCHED_MASK_EN
  logic [7:0]   v_mask;
`endif
  logic         v_elem_valid;
  logic [2:0]   v_elem_idx;
  logic [31:0]  v_elem_data;
  logic         v_done, busy;
  logic [1:0]   cache_vis_signal;
  logic [16:0]  data_addr;
  logic [2:0]   data_type;
  logic [31:0]  cache_written_data;
  logic [3:0]   length;
  logic [31:0]  data;
  logic [1:0]   d_cache_vis_status;

  dcache_access_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .s_req              (s_req),
    .s_is_store         (s_is_store),
    .s_addr             (s_addr),
    .s_type             (s_type),
    .s_wdata            (s_wdata),
    .s_ack              (s_ack),
    .s_rdata            (s_rdata),
    .v_req              (v_req),
    .v_is_store         (v_is_store),
    .v_base             (v_base),
    .v_stride           (v_stride),
    .v_len              (v_len),
    .v_type             (v_type),
    .v_wdata            (v_wdata),
`ifdef DCACHE_SCHED_MASK_EN
    .v_mask             (v_mask),
`endif
    .v_elem_valid       (v_elem_valid),
    .v_elem_idx         (v_elem_idx),
    .v_elem_data        (v_elem_data),
    .v_done             (v_done),
    .busy               (busy),
    .cache_vis_signal   (cache_vis_signal),
    .data_addr          (data_addr),
    .data_type          (data_type),
    .cache_written_data (cache_written_data),
    .length             (length),
    .data               (data),
    .d_cache_vis_status (d_cache_vis_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  cv;
    logic [16:0] addr;
    logic [2:0]  dt;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rd;
    logic        ev;
    logic [2:0]  idx;
    logic [31:0] ed;
    logic        done;
    logic        by;
  } out_t;

  typedef struct {
    logic         s_st;
    logic [16:0]  s_addr;
    logic [2:0]   s_type;
    logic [31:0]  s_wdata;
    logic         v_st;
    logic [16:0]  v_base;
    logic [16:0]  v_stride;
    logic [3:0]   v_len;
    logic [2:0]   v_type;
    logic [255:0] v_wdata;
  } op_t;

  typedef struct {
    int          op;
    logic        sr;
    logic        vr;
    logic [1:0]  st;
    logic [31:0] dat;
    out_t        exp;
  } row_t;

  op_t  ops [5];
  row_t rows [$];

  int checks   = 0;
  int failures = 0;

  logic         prev_issue;
  logic [16:0]  prev_addr;
  logic [16:0]  acc_q [$];
  logic [2:0]   idx_q [$];
  logic [31:0]  ed_q [$];
  logic [31:0]  rd_q [$];
  int           done_n, ack_n;

  function automatic out_t cap();
    out_t o;
    o.cv   = cache_vis_signal;
    o.addr = data_addr;
    o.dt   = data_type;
    o.wd   = cache_written_data;
    o.ack  = s_ack;
    o.rd   = s_rdata;
    o.ev   = v_elem_valid;
    o.idx  = v_elem_idx;
    o.ed   = v_elem_data;
    o.done = v_done;
    o.by   = busy;
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic r(input int op, input logic sr, input logic vr, input logic [1:0] st,
                   input logic [31:0] dat, input logic [1:0] cv, input logic [16:0] a,
                   input logic [2:0] dt, input logic [31:0] wd, input logic ack,
                   input logic [31:0] rd, input logic ev, input logic [2:0] idx,
                   input logic [31:0] ed, input logic dn, input logic by);
    row_t x;
    x.op  = op;
    x.sr  = sr;
    x.vr  = vr;
    x.st  = st;
    x.dat = dat;
    x.exp = '{cv, a, dt, wd, ack, rd, ev, idx, ed, dn, by};
    rows.push_back(x);
  endtask

  task automatic apply_op(input int k);
    s_is_store = ops[k].s_st;
    s_addr     = ops[k].s_addr;
    s_type     = ops[k].s_type;
    s_wdata    = ops[k].s_wdata;
    v_is_store = ops[k].v_st;
    v_base     = ops[k].v_base;
    v_stride   = ops[k].v_stride;
    v_len      = ops[k].v_len;
    v_type     = ops[k].v_type;
    v_wdata    = ops[k].v_wdata;
  endtask

  // One clock: answer last cycle's issue with FINISHED, then log outputs
  task automatic step();
    @(posedge clk);
    #1;
    d_cache_vis_status = prev_issue ? L_S_FINISHED : D_CACHE_RESTING;
    data = prev_issue ? (32'hC000_0000 | {15'd0, prev_addr}) : 32'd0;
    @(negedge clk);
    prev_issue = (cache_vis_signal != D_CACHE_NOP);
    prev_addr  = data_addr;
    if (prev_issue) acc_q.push_back(data_addr);
    if (v_elem_valid) begin
      idx_q.push_back(v_elem_idx);
      ed_q.push_back(v_elem_data);
    end
    if (v_done) done_n++;
    if (s_ack) begin
      ack_n++;
      rd_q.push_back(s_rdata);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    idx_q.delete();
    ed_q.delete();
    rd_q.delete();
    done_n     = 0;
    ack_n      = 0;
    prev_issue = 1'b0;
    prev_addr  = '0;
  endtask

  initial begin
    logic [16:0] exp_acc [6];
    bit          sent2;
    int          cyc;
    logic        timed_out;

    rst = 1'b1;
    s_req = 1'b0; v_req = 1'b0;
    d_cache_vis_status = D_CACHE_RESTING;
    data = '0;
`ifdef DCACHE_SCHED_MASK_EN
    v_mask = 8'hFF;
`endif
    for (int i = 0; i < 5; i++) ops[i] = '{default: '0};
    apply_op(0);
    clear_logs();

    // Operand sets
    ops[0].s_addr = 17'h00010; ops[0].s_type = FOUR_BYTE;
    ops[1].s_st = 1'b1; ops[1].s_addr = 17'h00020; ops[1].s_type = TWO_BYTE; ops[1].s_wdata = 32'h0000_1234;
    ops[2].v_base = 17'h00100; ops[2].v_stride = 17'd4; ops[2].v_len = 4'd4; ops[2].v_type = ONE_BYTE;
    ops[3].v_st = 1'b1; ops[3].v_base = 17'h1FFFE; ops[3].v_stride = 17'd2; ops[3].v_len = 4'd3;
    ops[3].v_type = TWO_BYTE;
    ops[3].v_wdata[31:0]  = 32'h1111_0000;
    ops[3].v_wdata[63:32] = 32'h2222_0001;
    ops[3].v_wdata[95:64] = 32'h3333_0002;
    ops[4].v_base = 17'h00300; ops[4].v_stride = 17'd4; ops[4].v_len = 4'd0;

    // Scalar load FOUR_BYTE, hit
    r(0,1,0,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,0);
    r(0,1,0,D_CACHE_RESTING,0,            D_CACHE_LOAD, 17'h10,FOUR_BYTE,0, 0,0,0,0,0,0,1);
    r(0,1,0,L_S_FINISHED,32'hDEADBEEF,    D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,1);
    r(0,0,0,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 1,32'hDEADBEEF,0,0,0,0,0);
    r(0,0,0,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,0);
    // Scalar store, cache busy on issue, one extra wait cycle
    r(1,1,0,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,0);
    r(1,1,0,ST_BUSY,0,                    D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,1);
    r(1,1,0,D_CACHE_RESTING,0,            D_CACHE_STORE,17'h20,TWO_BYTE,32'h1234, 0,0,0,0,0,0,1);
    r(1,1,0,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,1);
    r(1,1,0,L_S_FINISHED,32'hFFFFFFFF,    D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,1);
    r(1,0,0,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 1,0,0,0,0,0,0);
    // Vector load, base 0x100 stride 4 len 4
    r(2,0,1,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,0);
    for (int e = 0; e < 4; e++) begin
      r(2,0,1,D_CACHE_RESTING,0,          D_CACHE_LOAD, 17'h100 + 17'(4*e),ONE_BYTE,0, 0,0,0,0,0,0,1);
      r(2,0,1,L_S_FINISHED,32'hA0 + 32'(e), D_CACHE_NOP,0,0,0, 0,0,0,0,0,0,1);
      if (e < 3)
        r(2,0,1,D_CACHE_RESTING,0,        D_CACHE_NOP,  0,0,0, 0,0,1,3'(e),32'hA0 + 32'(e),0,1);
      else
        r(2,0,0,D_CACHE_RESTING,0,        D_CACHE_NOP,  0,0,0, 0,0,1,3'd3,32'hA3,1,0);
    end
    r(2,0,0,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,0);
    // Vector store with address wrap
    r(3,0,1,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,0);
    r(3,0,1,D_CACHE_RESTING,0,            D_CACHE_STORE,17'h1FFFE,TWO_BYTE,32'h11110000, 0,0,0,0,0,0,1);
    r(3,0,1,L_S_FINISHED,0,               D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,1);
    r(3,0,1,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,1);
    r(3,0,1,D_CACHE_RESTING,0,            D_CACHE_STORE,17'h00000,TWO_BYTE,32'h22220001, 0,0,0,0,0,0,1);
    r(3,0,1,L_S_FINISHED,0,               D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,1);
    r(3,0,1,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,1);
    r(3,0,1,D_CACHE_RESTING,0,            D_CACHE_STORE,17'h00002,TWO_BYTE,32'h33330002, 0,0,0,0,0,0,1);
    r(3,0,1,L_S_FINISHED,0,               D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,1);
    r(3,0,0,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,1,0);
    // Zero-length vector
    r(4,0,1,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,0);
    r(4,0,0,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,1,0);
    r(4,0,0,D_CACHE_RESTING,0,            D_CACHE_NOP,  0,0,0, 0,0,0,0,0,0,0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 128'(cap()), 128'(0));
    chk("reset_length", 128'(length), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table: inputs driven after the edge, outputs sampled on the falling edge
    for (int i = 0; i < rows.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      apply_op(rows[i].op);
      s_req = rows[i].sr;
      v_req = rows[i].vr;
      d_cache_vis_status = rows[i].st;
      data = rows[i].dat;
      @(negedge clk);
      chk($sformatf("row%0d", i), 128'(cap()), 128'(rows[i].exp));
    end

    // Simultaneous requests, then a scalar arriving during vector element 1
    clear_logs();
    d_cache_vis_status = D_CACHE_RESTING;
    s_req = 1'b1; s_is_store = 1'b0; s_addr = 17'h00040; s_type = FOUR_BYTE;
    v_req = 1'b1; v_is_store = 1'b0; v_base = 17'h00200; v_stride = 17'd4;
    v_len = 4'd4; v_type = ONE_BYTE; v_wdata = '0;
    sent2 = 1'b0;
    for (cyc = 0; cyc < 300 && !(done_n == 1 && ack_n == 2); cyc++) begin
      step();
      if (s_ack) s_req = 1'b0;
      if (v_done) v_req = 1'b0;
      if (!sent2 && prev_issue && data_addr == 17'h00204) begin
        s_req  = 1'b1;
        s_addr = 17'h00044;
        sent2  = 1'b1;
      end
    end
    timed_out = !(done_n == 1 && ack_n == 2);
    chk("preempt_timeout", 128'(timed_out), 128'(0));
    exp_acc = '{17'h00040, 17'h00200, 17'h00204, 17'h00044, 17'h00208, 17'h0020C};
    chk("preempt_acc_count", 128'(acc_q.size()), 128'(6));
    for (int i = 0; i < 6; i++)
      chk($sformatf("preempt_acc%0d", i), 128'((i < acc_q.size()) ? acc_q[i] : 17'h1FFFF), 128'(exp_acc[i]));
    chk("preempt_idx_count", 128'(idx_q.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("preempt_idx%0d", i), 128'((i < idx_q.size()) ? idx_q[i] : 3'd7), 128'(i));
      chk($sformatf("preempt_edata%0d", i), 128'((i < ed_q.size()) ? ed_q[i] : 32'd0),
          128'(32'hC000_0200 + 32'(4*i)));
    end
    chk("preempt_rdata0", 128'((rd_q.size() > 0) ? rd_q[0] : 32'd0), 128'(32'hC000_0040));
    chk("preempt_rdata1", 128'((rd_q.size() > 1) ? rd_q[1] : 32'd0), 128'(32'hC000_0044));

    // Reset while waiting on the cache abandons the transaction
    clear_logs();
    s_req = 1'b1; s_is_store = 1'b0; s_addr = 17'h00060; s_type = FOUR_BYTE;
    step();
    step();
    chk("rst_pre_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    s_req = 1'b0;
    step();
    chk("rst_mid_outputs", 128'(cap()), 128'(0));
    rst = 1'b0;
    repeat (4) step();
    chk("rst_no_ack_done", 128'({ack_n, done_n}), 128'(0));
    chk("rst_after_busy", 128'(busy), 128'(0));

`ifdef DCACHE_SCHED_MASK_EN
    // Masked elements: accesses only at base+0 and base+8
    clear_logs();
    v_req = 1'b1; v_is_store = 1'b0; v_base = 17'h00400; v_stride = 17'd4;
    v_len = 4'd4; v_type = ONE_BYTE; v_mask = 8'b0000_0101;
    for (cyc = 0; cyc < 100 && done_n == 0; cyc++) begin
      step();
      if (v_done) v_req = 1'b0;
    end
    chk("mask_done", 128'(done_n), 128'(1));
    chk("mask_acc_count", 128'(acc_q.size()), 128'(2));
    chk("mask_acc0", 128'((acc_q.size() > 0) ? acc_q[0] : 17'h1FFFF), 128'(17'h00400));
    chk("mask_acc1", 128'((acc_q.size() > 1) ? acc_q[1] : 17'h1FFFF), 128'(17'h00408));
    chk("mask_idx_count", 128'(idx_q.size()), 128'(2));
    chk("mask_idx0", 128'((idx_q.size() > 0) ? idx_q[0] : 3'd7), 128'(0));
    chk("mask_idx1", 128'((idx_q.size() > 1) ? idx_q[1] : 3'd7), 128'(2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
